// File: rtl/adc_dual_scan_sequencer.sv
// Dual Modular ADC scan controller: waits for a settled PLL lock, issues paired
// same-channel commands to ADC0/ADC1 and streams both responses as tagged samples.
module adc_dual_scan_sequencer #(
    parameter int NUM_CH         = 9,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DATA_W         = 12
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              pll_locked,
    output logic              pll_locked_to_adc,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              cmd0_valid,
    input  logic              cmd0_ready,
    output logic              cmd1_valid,
    input  logic              cmd1_ready,
    output logic [4:0]        cmd_channel,
    output logic              cmd_sop_eop,
    input  logic              rsp0_valid,
    input  logic [4:0]        rsp0_channel,
    input  logic [DATA_W-1:0] rsp0_data,
    input  logic              rsp1_valid,
    input  logic [4:0]        rsp1_channel,
    input  logic [DATA_W-1:0] rsp1_data,
    output logic              smp_valid,
    output logic              smp_adc,
    output logic [4:0]        smp_channel,
    output logic [DATA_W-1:0] smp_data,
    input  logic              err_clear,
    output logic              err_timeout,
    output logic              err_mismatch,
    output logic              busy
);

    localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(((SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES) + 1);

    typedef enum logic [2:0] {IDLE, SETTLE, SELECT, ISSUE, WAIT_RSP, EMIT0, EMIT1} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [4:0]          cur_idx, next_idx;
    logic                found, go_select;
    logic                acc0, acc1, got0, got1;
    logic                hs0, hs1, lat0, lat1;
    logic                both_acc, both_got, timeout_hit, mismatch_hit;
    logic [4:0]          rsp0_ch_q, rsp1_ch_q;
    logic [DATA_W-1:0]   rsp0_data_q, rsp1_data_q;

    // Circular search for the next enabled channel strictly after cur_idx; the
    // last candidate is cur_idx itself, so a single set bit repeats.
    always_comb begin
        int cand;
        next_idx = cur_idx;
        found    = 1'b0;
        cand     = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = int'(cur_idx) + k;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (!found && ch_mask[cand[IW-1:0]]) begin
                found    = 1'b1;
                next_idx = 5'(cand);
            end
        end
    end

    assign go_select  = pll_locked && enable && found;
    assign cmd0_valid = pll_locked && (state == ISSUE) && !acc0;
    assign cmd1_valid = pll_locked && (state == ISSUE) && !acc1;
    assign cmd_sop_eop = cmd0_valid || cmd1_valid;
    assign hs0 = cmd0_valid && cmd0_ready;
    assign hs1 = cmd1_valid && cmd1_ready;

    // A response counts only once its own command has been accepted in an earlier cycle.
    assign lat0 = pll_locked && !got0 && rsp0_valid && (((state == ISSUE) && acc0) || (state == WAIT_RSP));
    assign lat1 = pll_locked && !got1 && rsp1_valid && (((state == ISSUE) && acc1) || (state == WAIT_RSP));

    assign both_acc     = (acc0 || hs0) && (acc1 || hs1);
    assign both_got     = (got0 || lat0) && (got1 || lat1);
    assign timeout_hit  = pll_locked && (state == WAIT_RSP) && !both_got && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign mismatch_hit = (lat0 && (rsp0_channel != cmd_channel)) || (lat1 && (rsp1_channel != cmd_channel));
    assign busy         = (state != IDLE) && (state != SETTLE);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!pll_locked) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:     state_next = SETTLE;
                SETTLE:   if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_next = SELECT;
                SELECT:   if (go_select) state_next = ISSUE;
                ISSUE:    if (both_acc) state_next = WAIT_RSP;
                WAIT_RSP: begin
                    if (both_got)         state_next = EMIT0;
                    else if (timeout_hit) state_next = SELECT;
                end
                EMIT0:    state_next = EMIT1;
                EMIT1:    state_next = SELECT;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Counters, handshake/response capture and sticky errors (set wins over clear).
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pll_locked_to_adc <= 1'b0;
            cnt          <= '0;
            cur_idx      <= 5'(NUM_CH - 1);
            cmd_channel  <= '0;
            acc0         <= 1'b0;
            acc1         <= 1'b0;
            got0         <= 1'b0;
            got1         <= 1'b0;
            rsp0_ch_q    <= '0;
            rsp1_ch_q    <= '0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            err_timeout  <= 1'b0;
            err_mismatch <= 1'b0;
        end else begin
            pll_locked_to_adc <= pll_locked;
            err_timeout  <= (err_timeout && !err_clear) || timeout_hit;
            err_mismatch <= (err_mismatch && !err_clear) || mismatch_hit;
            if (hs0) acc0 <= 1'b1;
            if (hs1) acc1 <= 1'b1;
            if (lat0) begin
                got0        <= 1'b1;
                rsp0_ch_q   <= rsp0_channel;
                rsp0_data_q <= rsp0_data;
            end
            if (lat1) begin
                got1        <= 1'b1;
                rsp1_ch_q   <= rsp1_channel;
                rsp1_data_q <= rsp1_data;
            end
            case (state)
                IDLE:     cnt <= '0;
                SETTLE:   cnt <= cnt + CNT_W'(1);
                SELECT: begin
                    if (go_select) begin
                        cur_idx     <= next_idx;
                        cmd_channel <= next_idx;
                        acc0        <= 1'b0;
                        acc1        <= 1'b0;
                        got0        <= 1'b0;
                        got1        <= 1'b0;
                    end
                end
                ISSUE:    cnt <= '0;
                WAIT_RSP: cnt <= cnt + CNT_W'(1);
                default:  ;
            endcase
        end
    end

    always_comb begin
        smp_valid   = 1'b0;
        smp_adc     = 1'b0;
        smp_channel = '0;
        smp_data    = '0;
        if (pll_locked && (state == EMIT0)) begin
            smp_valid   = 1'b1;
            smp_channel = rsp0_ch_q;
            smp_data    = rsp0_data_q;
        end else if (pll_locked && (state == EMIT1)) begin
            smp_valid   = 1'b1;
            smp_adc     = 1'b1;
            smp_channel = rsp1_ch_q;
            smp_data    = rsp1_data_q;
        end
    end

endmodule

// File: tb/tb_adc_dual_scan_sequencer.sv
// Bench for adc_dual_scan_sequencer: table-driven scan pairs plus hand-written
// corner sequences; emitted samples are checked against a scoreboard queue.
module tb_adc_dual_scan_sequencer;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        pll_locked;
    logic        pll_locked_to_adc;
    logic        enable;
    logic [8:0]  ch_mask;
    logic        cmd0_valid, cmd0_ready, cmd1_valid, cmd1_ready;
    logic [4:0]  cmd_channel;
    logic        cmd_sop_eop;
    logic        rsp0_valid, rsp1_valid;
    logic [4:0]  rsp0_channel, rsp1_channel;
    logic [11:0] rsp0_data, rsp1_data;
    logic        smp_valid, smp_adc;
    logic [4:0]  smp_channel;
    logic [11:0] smp_data;
    logic        err_clear, err_timeout, err_mismatch, busy;

    typedef struct packed {
        logic        adc;
        logic [4:0]  ch;
        logic [11:0] data;
    } smp_t;

    typedef struct {
        logic [8:0]  mask;
        logic [4:0]  ch;
        logic [11:0] d0;
        logic [11:0] d1;
    } vec_t;

    smp_t exp_q[$];
    vec_t vecs[12];
    int   tests = 0;
    int   fails = 0;
    int   n;
    int   cmd_seen;

    adc_dual_scan_sequencer #(
        .NUM_CH(9), .SETTLE_CYCLES(64), .TIMEOUT_CYCLES(1024), .DATA_W(12)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .pll_locked(pll_locked), .pll_locked_to_adc(pll_locked_to_adc),
        .enable(enable), .ch_mask(ch_mask),
        .cmd0_valid(cmd0_valid), .cmd0_ready(cmd0_ready),
        .cmd1_valid(cmd1_valid), .cmd1_ready(cmd1_ready),
        .cmd_channel(cmd_channel), .cmd_sop_eop(cmd_sop_eop),
        .rsp0_valid(rsp0_valid), .rsp0_channel(rsp0_channel), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_channel(rsp1_channel), .rsp1_data(rsp1_data),
        .smp_valid(smp_valid), .smp_adc(smp_adc), .smp_channel(smp_channel), .smp_data(smp_data),
        .err_clear(err_clear), .err_timeout(err_timeout), .err_mismatch(err_mismatch),
        .busy(busy)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    // One clock step; any sample strobe seen mid-cycle is popped from the scoreboard.
    task automatic tick();
        smp_t e;
        @(negedge clk_clk);
        if (!reset_reset && smp_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_sample: got adc=%0d ch=%0d data=%h, required no sample",
                         smp_adc, smp_channel, smp_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("smp_adc", 32'(smp_adc), 32'(e.adc));
                checkOutput("smp_channel", 32'(smp_channel), 32'(e.ch));
                checkOutput("smp_data", 32'(smp_data), 32'(e.data));
            end
        end
        @(posedge clk_clk);
        #1;
    endtask

    task automatic waitCmd(input string name, input logic [4:0] exp_ch);
        int k;
        k = 0;
        while (!(cmd0_valid && cmd1_valid) && k < 300) begin
            tick();
            k++;
        end
        checkOutput({name, "_cmd_issued"}, 32'(cmd0_valid && cmd1_valid), 1);
        checkOutput({name, "_cmd_channel"}, 32'(cmd_channel), 32'(exp_ch));
    endtask

    // Runs one command pair: ready delays and response latencies are per ADC.
    task automatic applyStimulus(input string name, input logic [4:0] exp_ch,
                                 input int rd0, input int rd1, input int lat0, input int lat1,
                                 input logic [4:0] ch0_rsp, input logic [11:0] d0, input logic [11:0] d1);
        int a0, a1, beats0, beats1;
        bit r0done, r1done;
        waitCmd(name, exp_ch);
        checkOutput({name, "_sop_eop"}, 32'(cmd_sop_eop), 1);
        a0 = -1; a1 = -1; beats0 = 0; beats1 = 0; r0done = 0; r1done = 0;
        for (int c = 0; c < 100 && !(r0done && r1done); c++) begin
            cmd0_ready   = (c >= rd0);
            cmd1_ready   = (c >= rd1);
            rsp0_valid   = (a0 >= 0) && (c == a0 + lat0);
            rsp1_valid   = (a1 >= 0) && (c == a1 + lat1);
            rsp0_channel = ch0_rsp;
            rsp1_channel = exp_ch;
            rsp0_data    = d0;
            rsp1_data    = d1;
            if ((rsp0_valid && !r0done && r1done) || (rsp1_valid && !r1done && (r0done || rsp0_valid))) begin
                exp_q.push_back('{adc: 1'b0, ch: ch0_rsp, data: d0});
                exp_q.push_back('{adc: 1'b1, ch: exp_ch, data: d1});
            end
            if (rsp0_valid) r0done = 1;
            if (rsp1_valid) r1done = 1;
            if (cmd0_valid && cmd0_ready) begin beats0++; if (a0 < 0) a0 = c; end
            if (cmd1_valid && cmd1_ready) begin beats1++; if (a1 < 0) a1 = c; end
            tick();
        end
        cmd0_ready = 0; cmd1_ready = 0; rsp0_valid = 0; rsp1_valid = 0;
        checkOutput({name, "_responses_done"}, 32'(r0done && r1done), 1);
        checkOutput({name, "_beats0"}, 32'(beats0), 1);
        checkOutput({name, "_beats1"}, 32'(beats1), 1);
    endtask

    initial begin
        vecs[0]  = '{9'b100100101, 5'd0, 12'h123, 12'h456};
        vecs[1]  = '{9'b100100101, 5'd2, 12'hFFF, 12'h000};
        vecs[2]  = '{9'b100100101, 5'd5, 12'h000, 12'hFFF};
        vecs[3]  = '{9'b100100101, 5'd8, 12'hA5A, 12'h5A5};
        vecs[4]  = '{9'b100100101, 5'd0, 12'h001, 12'h800};
        vecs[5]  = '{9'b100100101, 5'd2, 12'h7FE, 12'h3C3};
        vecs[6]  = '{9'b000010000, 5'd4, 12'h111, 12'h222};
        vecs[7]  = '{9'b000010000, 5'd4, 12'h333, 12'h444};
        vecs[8]  = '{9'b000000011, 5'd0, 12'h0F0, 12'hF0F};
        vecs[9]  = '{9'b000000011, 5'd1, 12'h246, 12'h8AC};
        vecs[10] = '{9'b100000000, 5'd8, 12'hBEE, 12'hCAB};
        vecs[11] = '{9'b111111111, 5'd0, 12'h9DE, 12'h0AD};

        reset_reset = 1; pll_locked = 0; enable = 0; ch_mask = '0;
        cmd0_ready = 0; cmd1_ready = 0; rsp0_valid = 0; rsp1_valid = 0;
        rsp0_channel = '0; rsp1_channel = '0; rsp0_data = '0; rsp1_data = '0; err_clear = 0;
        repeat (3) @(posedge clk_clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_cmd_valid", 32'({cmd0_valid, cmd1_valid, cmd_sop_eop}), 0);
        checkOutput("reset_cmd_channel", 32'(cmd_channel), 0);
        checkOutput("reset_smp_valid", 32'(smp_valid), 0);
        checkOutput("reset_errors", 32'({err_timeout, err_mismatch}), 0);
        checkOutput("reset_pll_copy", 32'(pll_locked_to_adc), 0);
        reset_reset = 0;
        tick();

        // Lock bring-up: first command 66 cycles after lock rises.
        ch_mask = 9'b100100101; enable = 1; pll_locked = 1;
        #1;
        checkOutput("pll_copy_registered", 32'(pll_locked_to_adc), 0);
        tick();
        n = 1;
        checkOutput("pll_copy_after_edge", 32'(pll_locked_to_adc), 1);
        checkOutput("settle_not_busy", 32'(busy), 0);
        while (!cmd0_valid && n < 200) begin tick(); n++; end
        checkOutput("bringup_latency", 32'(n), 66);

        for (int i = 0; i < 12; i++) begin
            ch_mask = vecs[i].mask;
            applyStimulus($sformatf("vec%0d", i), vecs[i].ch, 0, 0, 3, 3, vecs[i].ch, vecs[i].d0, vecs[i].d1);
        end

        // Skewed handshake: ADC1 answers before ADC0 even accepts.
        applyStimulus("skew", 5'd1, 5, 0, 3, 2, 5'd1, 12'h5C1, 12'h5C2);
        checkOutput("skew_no_mismatch", 32'(err_mismatch), 0);

        applyStimulus("mismatch", 5'd2, 0, 0, 3, 3, 5'd3, 12'hD00, 12'hD01);
        checkOutput("mismatch_flag", 32'(err_mismatch), 1);
        err_clear = 1; tick(); err_clear = 0;
        checkOutput("mismatch_cleared", 32'(err_mismatch), 0);

        // Timeout: ADC1 never answers.
        waitCmd("timeout", 5'd3);
        cmd0_ready = 1; cmd1_ready = 1; tick(); cmd0_ready = 0; cmd1_ready = 0;
        n = 0;
        rsp0_channel = 5'd3; rsp0_data = 12'hEEE;
        while (!err_timeout && n < 2000) begin
            rsp0_valid = (n == 2);
            tick();
            n++;
        end
        rsp0_valid = 0;
        checkOutput("timeout_cycles", 32'(n), 1024);
        waitCmd("after_timeout", 5'd4);
        err_clear = 1; tick(); err_clear = 0;
        checkOutput("timeout_cleared", 32'(err_timeout), 0);
        applyStimulus("ch4", 5'd4, 0, 0, 3, 3, 5'd4, 12'h404, 12'h405);

        // Lock loss in WAIT_RSP, late responses dropped, rescan after full settle.
        waitCmd("lockloss", 5'd5);
        cmd0_ready = 1; cmd1_ready = 1; tick(); cmd0_ready = 0; cmd1_ready = 0;
        tick();
        pll_locked = 0;
        tick();
        checkOutput("lockloss_idle", 32'(busy), 0);
        rsp0_valid = 1; rsp1_valid = 1; rsp0_channel = 5'd5; rsp1_channel = 5'd5;
        repeat (2) tick();
        rsp0_valid = 0; rsp1_valid = 0;
        repeat (3) tick();
        pll_locked = 1;
        n = 0;
        while (!cmd0_valid && n < 200) begin tick(); n++; end
        checkOutput("relock_latency", 32'(n), 66);
        checkOutput("relock_channel", 32'(cmd_channel), 6);

        // enable drops mid-pair: pair finishes, then the block parks in SELECT.
        enable = 0;
        applyStimulus("ch6", 5'd6, 0, 0, 3, 3, 5'd6, 12'h606, 12'h607);
        cmd_seen = 0;
        repeat (10) begin tick(); if (cmd0_valid || cmd1_valid) cmd_seen++; end
        checkOutput("disabled_no_cmd", 32'(cmd_seen), 0);
        checkOutput("disabled_busy", 32'(busy), 1);
        enable = 1;
        applyStimulus("ch7", 5'd7, 0, 0, 3, 3, 5'd7, 12'h707, 12'h708);

        // Asynchronous reset in the middle of a pair.
        waitCmd("midreset", 5'd8);
        cmd0_ready = 1; cmd1_ready = 1; tick(); cmd0_ready = 0; cmd1_ready = 0;
        tick();
        #2 reset_reset = 1;
        #1;
        checkOutput("midreset_busy", 32'(busy), 0);
        checkOutput("midreset_cmd_channel", 32'(cmd_channel), 0);
        checkOutput("midreset_pll_copy", 32'(pll_locked_to_adc), 0);
        rsp0_valid = 1; rsp1_valid = 1;
        tick();
        rsp0_valid = 0; rsp1_valid = 0;
        tick();
        reset_reset = 0;
        n = 0;
        while (!cmd0_valid && n < 200) begin tick(); n++; end
        checkOutput("post_reset_latency", 32'(n), 66);
        applyStimulus("post_reset", 5'd0, 0, 0, 3, 3, 5'd0, 12'h0C0, 12'h0C1);

        repeat (5) tick();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
